// File: rtl/alu_mdu_pkg.sv
// Shared opcode constants and FSM state type for the alu_mdu execute unit.
package alu_mdu_pkg;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    localparam logic [6:0] FCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

endpackage

// File: rtl/alu_div.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// followed by a single sign-fixup cycle. The caller guarantees divisor != 0.
module alu_div
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t          state, state_next;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q;
    logic            neg_q, neg_r, rem_sel;
    logic            a_neg, b_neg;
    logic [XLEN:0]   shifted;
    logic            fits;
    logic [XLEN-1:0] q_fix, r_fix;

    // NOTE: state registers use non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: next-state defaults to the current state first, so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = DIV;
            DIV:     if (count == '0) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign a_neg   = is_signed & dividend[XLEN-1];
    assign b_neg   = is_signed & divisor[XLEN-1];
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign fits    = shifted >= {1'b0, dvs_q};

    // NOTE: datapath registers have no reset; start always loads them before they are read.
    always_ff @(posedge clk) begin
        if (start && state == IDLE) begin
            rem_q   <= '0;
            quo_q   <= a_neg ? -dividend : dividend;
            dvs_q   <= b_neg ? -divisor : divisor;
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            rem_sel <= is_rem;
            count   <= CW'(XLEN - 1);
        end else if (state == DIV) begin
            rem_q <= fits ? XLEN'(shifted - {1'b0, dvs_q}) : shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], fits};
            count <= count - 1'b1;
        end
    end

    // MIN / -1 needs no special case: |MIN| = 2^(XLEN-1), negated back to MIN.
    assign q_fix  = neg_q ? -quo_q : quo_q;
    assign r_fix  = neg_r ? -rem_q : rem_q;
    assign result = rem_sel ? r_fix : q_fix;
    assign busy   = (state != IDLE);
    assign done   = (state == FIX);

endmodule

// File: rtl/alu_mdu.sv
// RV32I/RV64I integer ALU merged with the M extension. Base ops and divide by
// zero finish on the accept edge, multiply in two edges, divide in XLEN+2.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            REQ,
    input  logic            RCC,
    input  logic [2:0]      FCT3,
    input  logic [6:0]      FCT7,
    input  logic [XLEN-1:0] S1,
    input  logic [XLEN-1:0] S2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RDATA
);

    localparam int SHW = $clog2(XLEN);

    state_t            state, state_next;
    logic              accept, is_m, is_mul, is_div, div_zero, div_start;
    logic              sub_op, sra_op;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res, dz_res;
    logic              mul_a_sgn, mul_b_sgn, div_sgn, div_rem;
    logic [2*XLEN-1:0] mul_a, mul_b, prod_q;
    logic              mul_hi_q;
    logic              div_busy, div_done;
    logic [XLEN-1:0]   div_result;

    assign BUSY      = (state != IDLE) || div_busy;
    assign accept    = REQ && !BUSY;
    assign is_m      = MDU_EN && RCC && (FCT7 == FCT7_MULDIV);
    assign is_mul    = is_m && !FCT3[2];
    assign is_div    = is_m && FCT3[2];
    assign div_zero  = is_div && (S2 == '0);
    assign div_start = accept && is_div && !div_zero;
    assign sub_op    = RCC && FCT7[5];
    assign sra_op    = FCT7[5];
    assign shamt     = S2[SHW-1:0];

    always_comb begin
        base_res = '0;
        case (FCT3)
            F3_ADD:  base_res = sub_op ? S1 - S2 : S1 + S2;
            F3_SLL:  base_res = S1 << shamt;
            F3_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(S1) < $signed(S2)};
            F3_SLTU: base_res = {{(XLEN-1){1'b0}}, S1 < S2};
            F3_XOR:  base_res = S1 ^ S2;
            F3_SRL:  base_res = sra_op ? $unsigned($signed(S1) >>> shamt) : (S1 >> shamt);
            F3_OR:   base_res = S1 | S2;
            F3_AND:  base_res = S1 & S2;
        endcase
    end

    always_comb begin
        mul_a_sgn = 1'b0;
        mul_b_sgn = 1'b0;
        div_sgn   = 1'b0;
        div_rem   = 1'b0;
        case (FCT3)
            F3_MULH:   begin mul_a_sgn = 1'b1; mul_b_sgn = 1'b1; end
            F3_MULHSU: mul_a_sgn = 1'b1;
            F3_DIV:    div_sgn = 1'b1;
            F3_REM:    begin div_sgn = 1'b1; div_rem = 1'b1; end
            F3_REMU:   div_rem = 1'b1;
            F3_MUL, F3_MULHU, F3_DIVU: ;
        endcase
    end

    assign dz_res = div_rem ? S1 : '1;

    // Extending to 2*XLEN makes the unsigned product's low half the exact signed product.
    assign mul_a = {{XLEN{mul_a_sgn & S1[XLEN-1]}}, S1};
    assign mul_b = {{XLEN{mul_b_sgn & S2[XLEN-1]}}, S2};

    always_ff @(posedge CLK) begin
        if (accept && is_mul) begin
            prod_q   <= mul_a * mul_b;
            mul_hi_q <= (FCT3 != F3_MUL);
        end
    end

    alu_div #(
        .XLEN(XLEN)
    ) u_div (
        .clk      (CLK),
        .rst      (RES),
        .start    (div_start),
        .is_signed(div_sgn),
        .is_rem   (div_rem),
        .dividend (S1),
        .divisor  (S2),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );

    always_ff @(posedge CLK) begin
        if (RES) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) state_next = MUL;
                else if (div_start)   state_next = DIV;
            end
            MUL:     state_next = IDLE;
            DIV:     if (div_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            DONE  <= 1'b0;
            RDATA <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_mul && !div_start) begin
                        DONE  <= 1'b1;
                        RDATA <= is_div ? dz_res : base_res;
                    end
                end
                MUL: begin
                    DONE  <= 1'b1;
                    RDATA <= mul_hi_q ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
                end
                DIV: begin
                    if (div_done) begin
                        DONE  <= 1'b1;
                        RDATA <= div_result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised and directed bench for alu_mdu at XLEN=32 and XLEN=64, checked
// against a wide-integer arithmetic reference model.
module tb_alu_mdu;

    typedef logic signed [129:0] wide_t;

    logic        clk = 1'b0;
    logic        res;
    logic        rcc;
    logic [2:0]  fct3;
    logic [6:0]  fct7;
    logic        req32, req64;
    logic [31:0] s1_32, s2_32, rdata32;
    logic [63:0] s1_64, s2_64, rdata64;
    logic        busy32, done32, busy64, done64;

    int n_checks = 0;
    int n_pass   = 0;
    int lat;
    int stale;
    bit seen;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(32), .MDU_EN(1'b1)) dut32 (
        .CLK(clk), .RES(res), .REQ(req32), .RCC(rcc), .FCT3(fct3), .FCT7(fct7),
        .S1(s1_32), .S2(s2_32), .BUSY(busy32), .DONE(done32), .RDATA(rdata32)
    );

    alu_mdu #(.XLEN(64), .MDU_EN(1'b1)) dut64 (
        .CLK(clk), .RES(res), .REQ(req64), .RCC(rcc), .FCT3(fct3), .FCT7(fct7),
        .S1(s1_64), .S2(s2_64), .BUSY(busy64), .DONE(done64), .RDATA(rdata64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [63:0] ref_result(input int xlen, input bit r, input logic [6:0] f7,
                                               input logic [2:0] f3, input logic [63:0] a,
                                               input logic [63:0] b);
        wide_t ua, ub, sa, sb, v, span;
        logic [63:0] mask;
        int sh;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        span = 1;
        span = span <<< xlen;
        ua = '0;
        ua[63:0] = a & mask;
        ub = '0;
        ub[63:0] = b & mask;
        sa = a[xlen-1] ? ua - span : ua;
        sb = b[xlen-1] ? ub - span : ub;
        sh = int'(b[5:0]) % xlen;
        v = '0;
        if (r && f7 == 7'h01) begin
            case (f3)
                3'd0: v = sa * sb;
                3'd1: v = (sa * sb) >>> xlen;
                3'd2: v = (sa * ub) >>> xlen;
                3'd3: v = (ua * ub) >>> xlen;
                3'd4: v = (sb == 0) ? -1 : sa / sb;
                3'd5: v = (ub == 0) ? -1 : ua / ub;
                3'd6: v = (sb == 0) ? sa : sa % sb;
                default: v = (ub == 0) ? ua : ua % ub;
            endcase
        end else begin
            case (f3)
                3'd0: v = (r && f7[5]) ? ua - ub : ua + ub;
                3'd1: v = ua << sh;
                3'd2: v = (sa < sb) ? 1 : 0;
                3'd3: v = (ua < ub) ? 1 : 0;
                3'd4: v = ua ^ ub;
                3'd5: v = f7[5] ? (sa >>> sh) : (ua >> sh);
                3'd6: v = ua | ub;
                default: v = ua & ub;
            endcase
        end
        return v[63:0] & mask;
    endfunction

    function automatic int ref_latency(input int xlen, input bit r, input logic [6:0] f7,
                                       input logic [2:0] f3, input logic [63:0] b);
        logic [63:0] mask;
        mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        if (!(r && f7 == 7'h01)) return 1;
        if (!f3[2]) return 2;
        return ((b & mask) == 0) ? 1 : xlen + 2;
    endfunction

    function automatic logic [63:0] pick(input bit w64);
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'd0;
            1: v = 64'd1;
            2: v = 64'hFFFF_FFFF_FFFF_FFFF;
            3: v = w64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000;
            4: v = w64 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF;
            5: v = 64'($urandom_range(0, 15));
            default: v = {$urandom, $urandom};
        endcase
        return w64 ? v : {32'b0, v[31:0]};
    endfunction

    // Drops REQ and changes every operand so latching at accept is exercised.
    task automatic scramble();
        req32 = 1'b0;
        req64 = 1'b0;
        rcc   = 1'($urandom);
        fct3  = 3'($urandom);
        fct7  = 7'($urandom);
        s1_32 = $urandom;
        s2_32 = $urandom;
        s1_64 = {$urandom, $urandom};
        s2_64 = {$urandom, $urandom};
    endtask

    task automatic do_op(input string tag, input bit w64, input bit r, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                         input bit use_exp, input logic [63:0] exp_given);
        int xl, l, busy_n, exp_lat;
        logic [63:0] exp_res, got;
        bit done_seen;
        xl      = w64 ? 64 : 32;
        exp_res = use_exp ? exp_given : ref_result(xl, r, f7, f3, a, b);
        exp_lat = ref_latency(xl, r, f7, f3, b);
        @(negedge clk);
        rcc  = r;
        fct7 = f7;
        fct3 = f3;
        if (w64) begin
            s1_64 = a;
            s2_64 = b;
            req64 = 1'b1;
        end else begin
            s1_32 = a[31:0];
            s2_32 = b[31:0];
            req32 = 1'b1;
        end
        @(posedge clk);
        l = 1;
        busy_n = 0;
        done_seen = 1'b0;
        got = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) scramble();
            if ((w64 ? done64 : done32) == 1'b1) begin
                done_seen = 1'b1;
                got = w64 ? rdata64 : {32'b0, rdata32};
                check({tag, "/busy_at_done"}, 64'(w64 ? busy64 : busy32), 64'd0);
                break;
            end
            if (w64 ? busy64 : busy32) busy_n++;
            @(posedge clk);
            l++;
        end
        check({tag, "/done_seen"}, 64'(done_seen), 64'd1);
        if (done_seen) begin
            check({tag, "/res"}, got, exp_res);
            check({tag, "/lat"}, 64'(l), 64'(exp_lat));
            check({tag, "/busy_cycles"}, 64'(busy_n), 64'(exp_lat - 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        bit          w;
        bit          r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [63:0] a, b;

        res   = 1'b1;
        req32 = 1'b0;
        req64 = 1'b0;
        rcc   = 1'b0;
        fct3  = 3'd0;
        fct7  = 7'd0;
        s1_32 = '0;
        s2_32 = '0;
        s1_64 = '0;
        s2_64 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset/busy32", 64'(busy32), 64'd0);
        check("reset/done32", 64'(done32), 64'd0);
        check("reset/rdata32", 64'(rdata32), 64'd0);
        check("reset/busy64", 64'(busy64), 64'd0);
        check("reset/done64", 64'(done64), 64'd0);
        check("reset/rdata64", rdata64, 64'd0);
        res = 1'b0;

        do_op("sub",    0, 1, 7'h20, 3'd0, 64'd5, 64'd7, 1, 64'hFFFF_FFFE);
        do_op("sra",    0, 1, 7'h20, 3'd5, 64'h8000_0000, 64'd4, 1, 64'hF800_0000);
        do_op("srai",   0, 0, 7'h20, 3'd5, 64'h8000_0000, 64'd4, 1, 64'hF800_0000);
        do_op("mulh",   0, 1, 7'h01, 3'd1, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'h0);
        do_op("mulhu",  0, 1, 7'h01, 3'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFE);
        do_op("mul",    0, 1, 7'h01, 3'd0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, 64'h1);
        do_op("div",    0, 1, 7'h01, 3'd4, 64'hFFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFD);
        do_op("rem",    0, 1, 7'h01, 3'd6, 64'hFFFF_FFF9, 64'd2, 1, 64'hFFFF_FFFF);
        do_op("div_ov", 0, 1, 7'h01, 3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h8000_0000);
        do_op("rem_ov", 0, 1, 7'h01, 3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h0);
        do_op("divu0",  0, 1, 7'h01, 3'd5, 64'd123, 64'd0, 1, 64'hFFFF_FFFF);
        do_op("remu0",  0, 1, 7'h01, 3'd7, 64'd123, 64'd0, 1, 64'd123);
        do_op("mulhu64", 1, 1, 7'h01, 3'd3, 64'h8000_0000_0000_0000, 64'd4, 1, 64'd2);
        do_op("divu64", 1, 1, 7'h01, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 1,
              64'h5555_5555_5555_5555);

        // REQ held through a divide: the second op waits until the DONE cycle.
        @(negedge clk);
        rcc   = 1'b1;
        fct7  = 7'h01;
        fct3  = 3'd5;
        s1_32 = 32'd100;
        s2_32 = 32'd7;
        req32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fct7  = 7'h00;
        fct3  = 3'd0;
        s1_32 = 32'd10;
        s2_32 = 32'd20;
        lat   = 1;
        seen  = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done32) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("hold/done_seen", 64'(seen), 64'd1);
        check("hold/lat", 64'(lat), 64'd34);
        check("hold/res", 64'(rdata32), ref_result(32, 1, 7'h01, 3'd5, 64'd100, 64'd7));
        @(posedge clk);
        @(negedge clk);
        check("hold/next_done", 64'(done32), 64'd1);
        check("hold/next_res", 64'(rdata32), ref_result(32, 1, 7'h00, 3'd0, 64'd10, 64'd20));
        req32 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold/quiet", 64'(done32), 64'd0);

        // Reset in the middle of a divide abandons it without a DONE.
        rcc   = 1'b1;
        fct7  = 7'h01;
        fct3  = 3'd4;
        s1_32 = 32'd1000;
        s2_32 = 32'd3;
        req32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req32 = 1'b0;
        repeat (10) @(negedge clk);
        check("rst/busy_before", 64'(busy32), 64'd1);
        res = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst/busy", 64'(busy32), 64'd0);
        check("rst/done", 64'(done32), 64'd0);
        check("rst/rdata", 64'(rdata32), 64'd0);
        res   = 1'b0;
        stale = 0;
        repeat (50) begin
            @(negedge clk);
            if (done32) stale++;
        end
        check("rst/stale_done", 64'(stale), 64'd0);

        for (int i = 0; i < 60; i++) begin
            w = (i >= 36);
            r = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 4))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2, 3:    f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3 = 3'($urandom_range(0, 7));
            a  = pick(w);
            b  = pick(w);
            do_op($sformatf("rnd%0d", i), w, r, f7, f3, a, b, 0, 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Next-generation execute unit for the darkriscv core: XLEN-parametrised RV32I/RV64I integer ALU merged with the RISC-V M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Base ops and multiply complete with fixed short latency; divide/remainder use an iterative restoring divider.
- Sits between operand fetch and writeback; the core stalls on BUSY.

Parameters:
- XLEN, 32, datapath width (32 or 64); shift amount is S2[$clog2(XLEN)-1:0]
- MDU_EN, 1, 1 = M extension decoded; 0 = FCT7==7'b0000001 decodes as a base op via FCT7[5]

Ports:
- CLK  in  1  clock
- RES  in  1  synchronous active-high reset
- REQ  in  1  request; accepted on a rising CLK edge when REQ=1 and BUSY=0
- RCC  in  1  1 = register-register op (enables SUB and M ops), 0 = immediate op
- FCT3  in  3  funct3
- FCT7  in  7  funct7
- S1  in  XLEN  operand 1
- S2  in  XLEN  operand 2 (register or sign-extended immediate)
- BUSY  out  1  multi-cycle op in flight; further REQ ignored
- DONE  out  1  one-cycle pulse, RDATA valid
- RDATA  out  XLEN  result; held until the next DONE

Behaviour:
- Reset (RES=1 at an edge): state=IDLE, BUSY=0, DONE=0, RDATA=0. Any op in flight is abandoned; no DONE is produced for it.
- Latency L = edges from the accept edge to the edge that raises DONE, counting the accept edge.
- L=1 for base ops, L=2 for MUL*, L=XLEN+2 for DIV*/REM*, L=1 for divide by zero.
- BUSY rises after the accept edge for ops with L>1. BUSY falls on the same edge DONE rises, so a new REQ can be accepted in the DONE cycle.
- REQ while BUSY=1 is ignored and not queued. DONE is low except for exactly one cycle per accepted op.
- Operands and FCT fields are latched at accept; they may change afterwards.
- Base decode by FCT3:
  - 0: ADD; SUB when RCC=1 and FCT7[5]=1
  - 1: SLL
  - 2: SLT (signed)
  - 3: SLTU
  - 4: XOR
  - 5: SRL, or SRA when FCT7[5]=1
  - 6: OR
  - 7: AND
  - All results are XLEN bits, modulo 2^XLEN. SLT/SLTU return a zero-extended 0/1.
- M op when MDU_EN=1, RCC=1 and FCT7=7'b0000001. FCT3 selects:
  - 0: MUL (low XLEN)
  - 1: MULH (s×s)
  - 2: MULHSU (s×u)
  - 3: MULHU (u×u)
  - 4: DIV
  - 5: DIVU
  - 6: REM
  - 7: REMU
- Multiply: 2XLEN-bit product formed from (XLEN+1)-bit sign/zero-extended operands. Stage 1 registers the product; stage 2 selects the half.
- FSM states: IDLE, MUL, DIV, FIX.
  - IDLE → MUL on MUL* accept.
  - IDLE → DIV on a DIV*/REM* accept with divisor ≠ 0.
  - MUL → IDLE after 1 cycle (DONE).
  - DIV runs XLEN iterations, one quotient bit per cycle, on absolute values for signed ops; iteration counter counts XLEN-1 down to 0.
  - DIV → FIX when the counter reaches 0.
  - FIX applies sign correction (quotient negated if signs differ; remainder takes the dividend's sign), then → IDLE (DONE).
  - Accept-edge setup (operand latch, abs) plus XLEN iterations plus FIX gives L=XLEN+2.
- Division corner cases (RISC-V spec):
  - Divisor 0: quotient all-ones, remainder = dividend; resolved in IDLE with L=1.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0; falls out of the normal iteration plus fixup and must be checked.
- Base ops and divide-by-zero accepted at IDLE write RDATA directly; the FSM stays in IDLE.

Decomposition:
- Package alu_mdu_pkg holds:
  - FCT3 opcode constants (F3_ADD..F3_AND, F3_MUL..F3_REMU)
  - FCT7_MULDIV = 7'b0000001
  - state enum {IDLE, MUL, DIV, FIX}
- One sub-module alu_div (parameter XLEN):
  - start/busy/done handshake
  - signed/unsigned select and rem select
  - iterative restoring divider with fixup
- Base ALU and multiplier stay inline in alu_mdu.

Test Plan:
- ADD/SUB and shifts, XLEN=32:
  - RCC=1, FCT7=0x20, FCT3=0, S1=5, S2=7 → RDATA=0xFFFFFFFE, DONE one edge after accept, BUSY never high.
  - SRA S1=0x80000000, shamt=4 → 0xF8000000.
- MULH/MULHU:
  - S1=S2=0xFFFFFFFF: MULH → 0x00000000; MULHU → 0xFFFFFFFE; MUL → 0x00000001.
  - Each: DONE at L=2, BUSY high for exactly 1 cycle.
- DIV/REM signed:
  - S1=-7, S2=2: DIV → 0xFFFFFFFD, REM → 0xFFFFFFFF, DONE at L=34.
  - S1=0x80000000, S2=-1: DIV → 0x80000000, REM → 0.
- Divide by zero:
  - DIVU S1=123, S2=0 → 0xFFFFFFFF; REMU → 123; both L=1, no BUSY.
- Handshake:
  - REQ held high during a DIV → second op ignored until the DONE cycle, then accepted back-to-back.
  - RES asserted mid-DIV → BUSY=0, DONE=0, RDATA=0 next cycle, no stale DONE.
- XLEN=64 regression:
  - MULHU 2^63 × 4 → 2.
  - DIVU 2^64-1 / 3 → 0x5555555555555555, DONE at L=66.
